// File: rtl/pc_unit.sv
// IF-stage program counter: priority next-PC select, EPC capture, post-exception fetch bubbles.
// PC/PCValid/EPC/FlushBusy are registered (1 cycle); NPCSeq is combinational. Stall holds the PC only in RUN.
module pc_unit #(
  parameter int unsigned           AW           = 30,
  parameter logic [AW-1:0]         RESET_VEC    = 30'h00100000,
  parameter logic [AW-1:0]         EXC_VEC      = 30'h00100060,
  parameter int unsigned           FLUSH_CYCLES = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Stall,
  input  logic          RedirValid,
  input  logic [AW-1:0] RedirTarget,
  input  logic          ExcReq,
  input  logic [AW-1:0] ExcPC,
  input  logic          Eret,
  output logic [AW-1:0] PC,
  output logic          PCValid,
  output logic [AW-1:0] NPCSeq,
  output logic [AW-1:0] EPC,
  output logic          FlushBusy
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  localparam logic [3:0]    FLUSH_CNT = 4'(FLUSH_CYCLES);
  localparam logic [AW-1:0] ONE       = {{(AW-1){1'b0}}, 1'b1};

  logic [0:0]    state_q, state_nxt;
  logic [3:0]    cnt_q, cnt_nxt;
  logic [AW-1:0] pc_q, pc_nxt;
  logic [AW-1:0] epc_q, epc_nxt;
  logic          vld_q, vld_nxt;
  logic          busy_q, busy_nxt;
  logic [AW-1:0] pc_inc;

  assign pc_inc = pc_q + ONE;

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    pc_nxt    = pc_q;
    epc_nxt   = epc_q;
    vld_nxt   = vld_q;
    busy_nxt  = busy_q;

    case (state_q)
      RUN: begin
        if (ExcReq) begin
          epc_nxt = ExcPC;
          pc_nxt  = EXC_VEC;
          if (FLUSH_CNT != 4'd0) begin
            state_nxt = FLUSH;
            cnt_nxt   = FLUSH_CNT;
            vld_nxt   = 1'b0;
            busy_nxt  = 1'b1;
          end else begin
            vld_nxt = 1'b1;
          end
        end else if (Eret) begin
          pc_nxt  = epc_q;
          vld_nxt = 1'b1;
        end else if (RedirValid) begin
          pc_nxt = RedirTarget;
        end else if (!Stall) begin
          pc_nxt = pc_inc;
        end
      end

      FLUSH: begin
        // Bubbles drain unconditionally; every control input, nested exceptions included, is dropped here.
        cnt_nxt = cnt_q - 4'd1;
        pc_nxt  = EXC_VEC;
        if (cnt_q <= 4'd1) begin
          state_nxt = RUN;
          cnt_nxt   = 4'd0;
          vld_nxt   = 1'b1;
          busy_nxt  = 1'b0;
        end
      end

      default: begin
        state_nxt = RUN;
        cnt_nxt   = 4'd0;
        vld_nxt   = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      vld_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      pc_q    <= pc_nxt;
      epc_q   <= epc_nxt;
      vld_q   <= vld_nxt;
      busy_q  <= busy_nxt;
    end
  end

  assign PC        = pc_q;
  assign PCValid   = vld_q;
  assign NPCSeq    = pc_inc;
  assign EPC       = epc_q;
  assign FlushBusy = busy_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed plus randomized check of pc_unit against a bubble-count model of the fetch PC.
module tb_pc_unit;

  localparam int unsigned   AW     = 30;
  localparam logic [29:0]   RVEC   = 30'h00100000;
  localparam logic [29:0]   XVEC   = 30'h00100060;
  localparam int unsigned   NFLUSH = 2;

  logic        Clk = 1'b0;
  logic        Reset, Stall, RedirValid, ExcReq, Eret;
  logic [29:0] RedirTarget, ExcPC;
  logic [29:0] PC, NPCSeq, EPC;
  logic        PCValid, FlushBusy;

  int vectors = 0;
  int miscompares = 0;

  // Model: fetch address, validity, saved EPC, and how many invalid fetches remain.
  logic [29:0] m_pc, m_epc;
  logic        m_valid;
  int          m_left;

  pc_unit #(.AW(AW), .RESET_VEC(RVEC), .EXC_VEC(XVEC), .FLUSH_CYCLES(NFLUSH)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .RedirValid(RedirValid),
    .RedirTarget(RedirTarget), .ExcReq(ExcReq), .ExcPC(ExcPC), .Eret(Eret),
    .PC(PC), .PCValid(PCValid), .NPCSeq(NPCSeq), .EPC(EPC), .FlushBusy(FlushBusy)
  );

  always #5 Clk = ~Clk;

  task automatic model_step();
    if (Reset) begin
      m_pc = RVEC; m_valid = 1'b1; m_epc = '0; m_left = 0;
    end else if (m_left > 0) begin
      m_left  = m_left - 1;
      m_valid = (m_left == 0);
    end else if (ExcReq) begin
      m_epc   = ExcPC;
      m_pc    = XVEC;
      m_left  = NFLUSH;
      m_valid = (NFLUSH == 0);
    end else if (Eret) begin
      m_pc = m_epc; m_valid = 1'b1;
    end else if (RedirValid) begin
      m_pc = RedirTarget;
    end else if (!Stall) begin
      m_pc = m_pc + 30'd1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, got, exp, $time);
    end
  endtask

  // One clock: model advances with the edge, DUT compared at the following falling edge.
  task automatic cycle();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    chk("pc",      {2'b0, PC},       {2'b0, m_pc});
    chk("pcvalid", {31'b0, PCValid}, {31'b0, m_valid});
    chk("npcseq",  {2'b0, NPCSeq},   {2'b0, m_pc + 30'd1});
    chk("epc",     {2'b0, EPC},      {2'b0, m_epc});
    chk("busy",    {31'b0, FlushBusy}, {31'b0, (m_left > 0)});
  endtask

  task automatic idle();
    Reset = 0; Stall = 0; RedirValid = 0; ExcReq = 0; Eret = 0;
    RedirTarget = '0; ExcPC = '0;
  endtask

  initial begin
    m_pc = '0; m_epc = '0; m_valid = 1'b0; m_left = 0;
    idle();
    @(negedge Clk);

    // Reset and sequential fetch
    Reset = 1; cycle(); cycle();
    chk("rst_pc", {2'b0, PC}, 32'h00100000);
    chk("rst_vld", {31'b0, PCValid}, 32'd1);
    chk("rst_epc", {2'b0, EPC}, 32'h0);
    Reset = 0; cycle();
    chk("seq1", {2'b0, PC}, 32'h00100001);
    cycle();
    chk("seq2", {2'b0, PC}, 32'h00100002);

    // Stall holds; redirect overrides stall
    Stall = 1; cycle(); cycle();
    chk("stall", {2'b0, PC}, 32'h00100002);
    RedirValid = 1; RedirTarget = 30'h00100040; cycle();
    chk("redir", {2'b0, PC}, 32'h00100040);
    idle();

    // Exception with two bubbles, nested exception/redirect ignored in flush
    ExcReq = 1; ExcPC = 30'h00100005; cycle();
    chk("exc_epc", {2'b0, EPC}, 32'h00100005);
    chk("exc_pc", {2'b0, PC}, 32'h00100060);
    chk("exc_vld", {31'b0, PCValid}, 32'd0);
    chk("exc_busy", {31'b0, FlushBusy}, 32'd1);
    ExcPC = 30'h00100099; RedirValid = 1; RedirTarget = 30'h00000123; cycle();
    chk("nest_epc", {2'b0, EPC}, 32'h00100005);
    chk("nest_vld", {31'b0, PCValid}, 32'd0);
    chk("nest_pc", {2'b0, PC}, 32'h00100060);
    idle(); cycle();
    chk("flush_end_vld", {31'b0, PCValid}, 32'd1);
    chk("flush_end_pc", {2'b0, PC}, 32'h00100060);
    chk("flush_end_busy", {31'b0, FlushBusy}, 32'd0);
    cycle();
    chk("post_flush", {2'b0, PC}, 32'h00100061);

    // Eret beats stall; exception beats eret
    Eret = 1; Stall = 1; cycle();
    chk("eret", {2'b0, PC}, 32'h00100005);
    idle(); ExcReq = 1; Eret = 1; ExcPC = 30'h00100010; cycle();
    chk("exc_over_eret", {2'b0, PC}, 32'h00100060);
    idle(); cycle(); cycle();

    // Wrap and reset mid-flush
    RedirValid = 1; RedirTarget = 30'h3FFFFFFF; cycle();
    idle(); cycle();
    chk("wrap_pc", {2'b0, PC}, 32'h0);
    chk("wrap_npc", {2'b0, NPCSeq}, 32'h1);
    ExcReq = 1; ExcPC = 30'h00000042; cycle();
    idle(); Reset = 1; cycle();
    chk("rst_flush_pc", {2'b0, PC}, 32'h00100000);
    chk("rst_flush_vld", {31'b0, PCValid}, 32'd1);
    chk("rst_flush_busy", {31'b0, FlushBusy}, 32'd0);
    Reset = 0; cycle();
    chk("rst_flush_seq", {2'b0, PC}, 32'h00100001);

    // Randomized control traffic
    for (int i = 0; i < 3000; i++) begin
      Reset       = ($urandom_range(0, 99) < 2);
      ExcReq      = ($urandom_range(0, 99) < 7);
      Eret        = ($urandom_range(0, 99) < 7);
      RedirValid  = ($urandom_range(0, 99) < 15);
      Stall       = ($urandom_range(0, 99) < 25);
      RedirTarget = ($urandom_range(0, 9) == 0) ? 30'h3FFFFFFF : 30'($urandom);
      ExcPC       = 30'($urandom);
      cycle();
    end
    idle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
